spi_slave_frame_if: RTL



---
 rtl/spi_pkg.sv | 11 +
 rtl/spi_sync_edge.sv | 33 +++
 rtl/spi_slave_frame_if.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: word width constant and the target-side state type.
package spi_pkg;

  localparam int SPI_DATA_WIDTH = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_slv_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin, followed by one history
// flop that yields single-cycle rise/fall strobes in the clk domain.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] stages;
  logic                   prev;

  // Shift the pin through the synchronizer; prev holds the previous synced level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stages <= {SYNC_STAGES{RESET_VAL}};
      prev   <= RESET_VAL;
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], din};
      prev   <= stages[SYNC_STAGES-1];
    end
  end

  assign sync = stages[SYNC_STAGES-1];
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/spi_slave_frame_if.sv
// SPI target for mode 3 (sclk idles high, drive on fall, sample on rise),
// MSB-first words, oversampled by clk.  Optional build macro:
// SPI_SLAVE_LOOPBACK_EN - an empty transmit buffer at word start sends the
// last received word back instead of zero, and no underrun is flagged.
//
// tx handshake: a word is taken on any clk edge where tx_valid and tx_ready
// are both high; tx_ready is high exactly while the one-word holding buffer
// is empty.  rx side has no backpressure: rx_valid is a one-cycle strobe and
// rx_data holds until the next strobe.
module spi_slave_frame_if
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = SPI_DATA_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sclk,
  input  logic                  cs_bar,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_underrun,
  output logic                  frame_err,
  output spi_slv_state_t        state
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  logic sclk_sync, sclk_rise, sclk_fall;
  logic cs_sync, cs_rise, cs_fall;
  logic mosi_sync, mosi_rise, mosi_fall;
  logic unused_edges;

  logic                  buf_full;
  logic [DATA_WIDTH-1:0] tx_buf;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic [DATA_WIDTH-2:0] rx_shift;
  logic [CW-1:0]         bit_cnt;

  logic                  word_done;
  logic                  word_start;
  logic [DATA_WIDTH-1:0] rx_word;
  logic [DATA_WIDTH-1:0] start_value;
  logic                  start_underrun;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sclk_sync (
    .clk(clk), .reset(reset), .din(sclk),
    .sync(sclk_sync), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk(clk), .reset(reset), .din(cs_bar),
    .sync(cs_sync), .rise(cs_rise), .fall(cs_fall)
  );

  // mosi only needs the synchronized level; its strobes are left idle.
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
    .clk(clk), .reset(reset), .din(mosi),
    .sync(mosi_sync), .rise(mosi_rise), .fall(mosi_fall)
  );

  // Abort is level based on the synced chip select, and sclk level is only
  // consumed through its strobes.
  assign unused_edges = cs_rise ^ mosi_rise ^ mosi_fall ^ sclk_sync;

  assign tx_ready = ~buf_full;

  // Word boundary decode and the value a new word loads into the tx shifter.
  always_comb begin
    rx_word    = {rx_shift, mosi_sync};
    word_done  = (state == SHIFT) && !cs_sync && sclk_rise && (bit_cnt == LAST_BIT);
    word_start = ((state == IDLE) && cs_fall) || word_done;
`ifdef SPI_SLAVE_LOOPBACK_EN
    if (buf_full) begin
      start_value = tx_buf;
    end else if (word_done) begin
      start_value = rx_word;
    end else begin
      start_value = rx_data;
    end
    start_underrun = 1'b0;
`else
    start_value    = buf_full ? tx_buf : '0;
    start_underrun = ~buf_full;
`endif
  end

  // Holding buffer: an accepted write fills it, a word start drains it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_full <= 1'b0;
      tx_buf   <= '0;
    end else if (tx_valid && !buf_full) begin
      buf_full <= 1'b1;
      tx_buf   <= tx_data;
    end else if (word_start) begin
      buf_full <= 1'b0;
    end
  end

  // Frame state machine with registered pin and strobe outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      miso        <= 1'b0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      bit_cnt     <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_err   <= 1'b0;
      case (state)
        IDLE: begin
          miso <= 1'b0;
          if (cs_fall) begin
            state       <= SHIFT;
            tx_shift    <= start_value;
            bit_cnt     <= '0;
            tx_underrun <= start_underrun;
          end
        end
        SHIFT: begin
          if (cs_sync) begin
            // Chip select released: mid-word release drops the partial word.
            state     <= IDLE;
            miso      <= 1'b0;
            bit_cnt   <= '0;
            frame_err <= (bit_cnt != '0);
          end else begin
            if (sclk_fall) begin
              miso     <= tx_shift[DATA_WIDTH-1];
              tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
            end
            if (sclk_rise) begin
              rx_shift <= rx_word[DATA_WIDTH-2:0];
              if (word_done) begin
                rx_data     <= rx_word;
                rx_valid    <= 1'b1;
                tx_shift    <= start_value;
                bit_cnt     <= '0;
                tx_underrun <= start_underrun;
              end else begin
                bit_cnt <= bit_cnt + CW'(1);
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
